// File: rtl/dut_io_pkg.sv
// Shared state encoding and counter sizing for the dut_io load/run/drain sequencer.
package dut_io_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DRAIN   = 3'd4
  } seq_state_e;

  // clog2 with a floor of one bit so a single-word vector still has a counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((32'd1 << w) < n)) w++;
    return w;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dut_io_word_cnt.sv
// Word counter shared by LOAD and DRAIN: clear, increment on enable, terminal-count flag.
module dut_io_word_cnt
  import dut_io_pkg::*;
#(
  parameter int unsigned CW = cnt_width(8)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] last,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == last);

endmodule

// File: rtl/dut_io_seq.sv
// Load/run/drain sequencer between an AXI-side word stream and a DUT's lane vectors.
// Optional RUN watchdog: define DUT_IO_SEQ_TIMEOUT_EN to bound RUN by TIMEOUT_CYCLES.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | accepting DUT_IN_WORDS input words into the input lanes
// RUN     | DUT advancing until dut_done (or timeout)
// CAPTURE | one-cycle snapshot of all output lanes
// DRAIN   | streaming DUT_OUT_WORDS output words to the AXI side
module dut_io_seq
  import dut_io_pkg::*;
#(
  parameter int unsigned DUT_IN_WORDS   = 8,
  parameter int unsigned DUT_OUT_WORDS  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dut_input_vec_from_axi,
  output logic [31:0] dut_input_vec_addr,
  output logic        input_vec_en,
  output logic        input_vec_mode,
  input  logic [31:0] dut_output_vec_to_axi,
  output logic [31:0] dut_output_vec_addr,
  output logic        output_vec_en,
  output logic        output_vec_mode,
  output logic        dut_run,
  input  logic        dut_done,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam int unsigned CW = cnt_width(max_u(DUT_IN_WORDS, DUT_OUT_WORDS));
  localparam logic [CW-1:0] IN_LAST  = CW'(DUT_IN_WORDS - 1);
  localparam logic [CW-1:0] OUT_LAST = CW'(DUT_OUT_WORDS - 1);

  seq_state_e    state_q, state_d;
  logic          done_q, done_d;
  logic          start_acc, load_hs, drain_hs, tmo_hit;
  logic          cnt_clr, cnt_inc, cnt_tc;
  logic [CW-1:0] cnt, cnt_last;
  logic          live;
  logic          st_load, st_run, st_capture, st_drain;

  assign st_load    = (state_q == ST_LOAD);
  assign st_run     = (state_q == ST_RUN);
  assign st_capture = (state_q == ST_CAPTURE);
  assign st_drain   = (state_q == ST_DRAIN);

  assign start_acc = (state_q == ST_IDLE) && start;
  assign load_hs   = st_load && in_valid;
  assign drain_hs  = st_drain && out_ready;

  assign cnt_clr  = start_acc || st_capture;
  assign cnt_inc  = load_hs || drain_hs;
  assign cnt_last = st_drain ? OUT_LAST : IN_LAST;

  dut_io_word_cnt #(.CW(CW)) u_word_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .last  (cnt_last),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (load_hs && cnt_tc) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (dut_done || tmo_hit) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_hs && cnt_tc) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

`ifdef DUT_IO_SEQ_TIMEOUT_EN
  localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] run_cnt_q, run_cnt_d;
  logic          timeout_err_q, timeout_err_d;

  assign tmo_hit = st_run && (run_cnt_q == TMO_LAST);

  always_comb begin
    run_cnt_d     = st_run ? run_cnt_q + 1'b1 : '0;
    timeout_err_d = timeout_err_q;
    if (start_acc) begin
      timeout_err_d = 1'b0;
    end else if (tmo_hit && !dut_done) begin
      timeout_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      run_cnt_q     <= run_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = live && timeout_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
  if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
  end
`endif

  // Reset is synchronous, so outputs are also gated while it is held high.
  assign live = !reset;

  assign in_ready               = live && st_load;
  assign input_vec_en           = live && load_hs;
  assign input_vec_mode         = live && load_hs;
  assign dut_input_vec_from_axi = (live && st_load) ? in_word : '0;
  assign dut_input_vec_addr     = (live && st_load) ? WORD_W'(cnt) : '0;

  assign output_vec_en          = live && st_capture;
  assign output_vec_mode        = live && st_capture;
  assign out_valid              = live && st_drain;
  assign out_word               = (live && st_drain) ? dut_output_vec_to_axi : '0;
  assign dut_output_vec_addr    = (live && st_drain) ? WORD_W'(cnt) : '0;

  assign dut_run                = live && st_run;
  assign busy                   = live && (state_q != ST_IDLE);
  assign done                   = live && done_q;

endmodule

// File: tb/tb_dut_io_seq.sv
// Directed scoreboard bench for dut_io_seq with a small lane model standing in for the DUT.
`timescale 1ns/1ps
module tb_dut_io_seq;

  localparam int NW = 8;
  localparam logic [31:0] XK = 32'h5A5A_C3C3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] in_word = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        dut_done = 1'b0;
  logic        in_ready, out_valid, input_vec_en, input_vec_mode;
  logic        output_vec_en, output_vec_mode, dut_run, busy, done, timeout_err;
  logic [31:0] out_word, dut_input_vec_from_axi, dut_input_vec_addr;
  logic [31:0] dut_output_vec_to_axi, dut_output_vec_addr;

  logic [31:0] in_lanes  [NW];
  logic [31:0] out_lanes [NW];

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t in_q[$];
  exp_t out_q[$];

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int cap_cnt = 0;
  int t_load = 0;
  int t_done = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_word = '0;

  always #5 clk = ~clk;

  dut_io_seq #(
    .DUT_IN_WORDS   (NW),
    .DUT_OUT_WORDS  (NW),
    .TIMEOUT_CYCLES (16)
  ) u_dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .in_word                (in_word),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .out_word               (out_word),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .dut_input_vec_from_axi (dut_input_vec_from_axi),
    .dut_input_vec_addr     (dut_input_vec_addr),
    .input_vec_en           (input_vec_en),
    .input_vec_mode         (input_vec_mode),
    .dut_output_vec_to_axi  (dut_output_vec_to_axi),
    .dut_output_vec_addr    (dut_output_vec_addr),
    .output_vec_en          (output_vec_en),
    .output_vec_mode        (output_vec_mode),
    .dut_run                (dut_run),
    .dut_done               (dut_done),
    .busy                   (busy),
    .done                   (done),
    .timeout_err            (timeout_err)
  );

  // Stand-in DUT: lanes written by the unpack port, snapshot transforms them.
  always @(posedge clk) begin
    if (input_vec_en && input_vec_mode) in_lanes[dut_input_vec_addr[2:0]] <= dut_input_vec_from_axi;
    if (output_vec_en && output_vec_mode) begin
      for (int i = 0; i < NW; i++) out_lanes[i] <= in_lanes[i] ^ XK;
    end
  end
  assign dut_output_vec_to_axi = out_lanes[dut_output_vec_addr[2:0]];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] outs_vec();
    return 160'({in_ready, out_valid, input_vec_en, input_vec_mode, output_vec_en,
                 output_vec_mode, dut_run, busy, done, timeout_err, dut_input_vec_addr,
                 dut_output_vec_addr, out_word, dut_input_vec_from_axi});
  endfunction

  task automatic sample();
    exp_t e;
    if (input_vec_en) begin
      if (in_q.size() == 0) chk("in_unexpected", 160'(input_vec_en), 160'(0));
      else begin
        e = in_q.pop_front();
        chk("in_addr", 160'(dut_input_vec_addr), 160'(e.addr));
        chk("in_data", 160'(dut_input_vec_from_axi), 160'(e.data));
        chk("in_mode", 160'(input_vec_mode), 160'(1));
      end
    end
    if (output_vec_en) begin
      cap_cnt++;
      chk("cap_mode", 160'(output_vec_mode), 160'(1));
    end
    if (stall_prev) begin
      chk("hold_valid", 160'(out_valid), 160'(1));
      chk("hold_addr", 160'(dut_output_vec_addr), 160'(prev_addr));
      chk("hold_word", 160'(out_word), 160'(prev_word));
    end
    stall_prev = out_valid && !out_ready;
    prev_addr  = dut_output_vec_addr;
    prev_word  = out_word;
    if (out_valid && out_ready) begin
      if (out_q.size() == 0) chk("out_unexpected", 160'(out_valid), 160'(0));
      else begin
        e = out_q.pop_front();
        chk("out_addr", 160'(dut_output_vec_addr), 160'(e.addr));
        chk("out_word", 160'(out_word), 160'(e.data));
      end
    end
  endtask

  task automatic cyc();
    #1;
    sample();
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_busy", 160'(busy), 160'(1));
    chk("start_in_ready", 160'(in_ready), 160'(1));
    cap_cnt = 0;
    t_load  = cyc_n;
  endtask

  task automatic do_load(input logic [31:0] seed, input int gap_at, input int gap_len,
                         input int start_at);
    logic [31:0] w;
    for (int k = 0; k < NW; k++) begin
      if (k == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          in_valid = 1'b0;
          #1;
          chk("gap_no_wr", 160'(input_vec_en), 160'(0));
          cyc();
        end
      end
      w = (32'h1111_1111 * (k + 1)) ^ seed;
      in_valid = 1'b1;
      in_word  = w;
      start    = (k == start_at);
      in_q.push_back('{addr: 32'(k), data: w});
      out_q.push_back('{addr: 32'(k), data: w ^ XK});
      cyc();
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_word  = '0;
    chk("load_to_run", 160'(dut_run), 160'(1));
    chk("run_in_ready", 160'(in_ready), 160'(0));
  endtask

  task automatic do_run(input int run_len);
    for (int i = 0; i < run_len; i++) begin
      chk("run_active", 160'(dut_run), 160'(1));
      dut_done = (i == run_len - 1);
      cyc();
    end
    dut_done = 1'b0;
    chk("capture_en", 160'(output_vec_en), 160'(1));
  endtask

  task automatic do_drain(input bit bp);
    logic [3:0] pat;
    int n;
    pat = 4'b1001;
    n = 0;
    while (out_q.size() > 0 && n < 64) begin
      out_ready = bp ? pat[n % 4] : 1'b1;
      cyc();
      n++;
    end
    out_ready = 1'b0;
    chk("drain_bound", 160'(n < 64), 160'(1));
    t_done = cyc_n;
    chk("done_pulse", 160'(done), 160'(1));
    chk("done_busy", 160'(busy), 160'(0));
    chk("capture_count", 160'(cap_cnt), 160'(1));
    cyc();
    chk("done_one_cycle", 160'(done), 160'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_outs", outs_vec(), 160'(0));
    cyc();
    reset = 1'b0;
    cyc();
    chk("idle_outs", outs_vec(), 160'(0));

    dut_done = 1'b1;
    cyc();
    dut_done = 1'b0;
    chk("idle_ignores_done", 160'(busy), 160'(0));

    // Nominal: spec word values, continuous valid, done on the 5th RUN cycle.
    do_start();
    do_load(32'h0, -1, 0, -1);
    do_run(5);
    do_drain(1'b0);
    chk("latency", 160'(t_done - t_load), 160'(NW + 5 + 1 + NW));

    // Output backpressure.
    do_start();
    do_load(32'hF0F0_0F0F, -1, 0, -1);
    do_run(3);
    do_drain(1'b1);

    // Input gap of three cycles after word 2.
    do_start();
    do_load(32'h0000_FFFF, 3, 3, -1);
    do_run(2);
    do_drain(1'b0);

    // Start pulsed mid-LOAD must not disturb the sequence.
    do_start();
    do_load(32'h1234_5678, -1, 0, 3);
    chk("ign_start_busy", 160'(busy), 160'(1));
    do_run(1);
    do_drain(1'b0);

    // Reset while running, then a clean transaction.
    do_start();
    do_load(32'h0BAD_F00D, -1, 0, -1);
    cyc();
    cyc();
    chk("pre_reset_run", 160'(dut_run), 160'(1));
    reset = 1'b1;
    #1;
    chk("reset_mid_run", outs_vec(), 160'(0));
    @(negedge clk);
    cyc_n++;
    reset = 1'b0;
    #1;
    chk("after_reset", outs_vec(), 160'(0));
    @(negedge clk);
    cyc_n++;
    in_q.delete();
    out_q.delete();
    stall_prev = 1'b0;
    do_start();
    do_load(32'hCAFE_0000, -1, 0, -1);
    do_run(4);
    do_drain(1'b0);
    chk("post_reset_err", 160'(timeout_err), 160'(0));

`ifdef DUT_IO_SEQ_TIMEOUT_EN
    do_start();
    do_load(32'h7777_0001, -1, 0, -1);
    n = 0;
    while (dut_run === 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    chk("timeout_run_cycles", 160'(n), 160'(16));
    chk("timeout_capture", 160'(output_vec_en), 160'(1));
    chk("timeout_err_set", 160'(timeout_err), 160'(1));
    do_drain(1'b0);
    chk("timeout_err_sticky", 160'(timeout_err), 160'(1));
    do_start();
    chk("timeout_err_clear", 160'(timeout_err), 160'(0));
    do_load(32'h7777_0002, -1, 0, -1);
    do_run(2);
    do_drain(1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dut_io_seq.md
DUT_IO_SEQ -- requirements
Module: dut_io_seq

Interface
REQ-001 SHALL have parameter DUT_IN_WORDS, default 8, number of 32-bit words in the DUT input vector.
REQ-002 SHALL have parameter DUT_OUT_WORDS, default 8, number of 32-bit words in the DUT output vector.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum RUN length; used only when the timeout feature is compiled in.
REQ-004 SHALL have ports, in this order:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load/run/drain transaction.
- in_word  input  32  input-vector word from the AXI side.
- in_valid  input  1  in_word valid.
- in_ready  output  1  sequencer accepts in_word.
- out_word  output  32  output-vector word to the AXI side.
- out_valid  output  1  out_word valid.
- out_ready  input  1  AXI side accepts out_word.
- dut_input_vec_from_axi  output  32  word to the unpack stage.
- dut_input_vec_addr  output  32  word index into the input lanes.
- input_vec_en  output  1  input-lane write enable.
- input_vec_mode  output  1  1 = write the word at the address.
- dut_output_vec_to_axi  input  32  word selected from the output lanes (combinational on address).
- dut_output_vec_addr  output  32  word index into the output lanes.
- output_vec_en  output  1  output-lane enable.
- output_vec_mode  output  1  1 = snapshot all lanes; 0 = select word at the address.
- dut_run  output  1  DUT may advance.
- dut_done  input  1  DUT reports completion.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  one-cycle pulse on return to IDLE.
- timeout_err  output  1  sticky timeout flag (see Configuration).

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, RUN, CAPTURE, DRAIN.
REQ-006 IDLE: start=1 SHALL go to LOAD and clear the word counter; start in any other state SHALL be ignored.
REQ-007 LOAD: in_ready=1; on each in_valid&in_ready the block SHALL drive input_vec_en=1, input_vec_mode=1, dut_input_vec_from_axi=in_word and dut_input_vec_addr=counter in the same cycle (combinational pass-through), then increment the counter.
REQ-008 LOAD SHALL go to RUN on the handshake of word DUT_IN_WORDS-1; in_valid=0 SHALL stall without writing.
REQ-009 RUN: dut_run=1; dut_done=1 SHALL go to CAPTURE on the next edge; dut_done SHALL be ignored outside RUN.
REQ-010 CAPTURE SHALL last exactly one cycle with output_vec_en=1 and output_vec_mode=1, then go to DRAIN with the counter cleared.
REQ-011 DRAIN: out_valid=1, output_vec_mode=0, dut_output_vec_addr=counter, out_word=dut_output_vec_to_axi; the counter SHALL advance only on out_valid&out_ready.
REQ-012 out_word and dut_output_vec_addr SHALL remain stable while out_valid=1 and out_ready=0.
REQ-013 DRAIN SHALL go to IDLE on the handshake of word DUT_OUT_WORDS-1 and assert done=1 for exactly that next cycle.
REQ-014 Address outputs SHALL be zero-extended counter values of width clog2(max(DUT_IN_WORDS, DUT_OUT_WORDS)); enables SHALL be 0 outside the states listed above.
REQ-015 Minimum transaction latency SHALL be DUT_IN_WORDS + RUN cycles + 1 + DUT_OUT_WORDS cycles from start to done.

Reset
REQ-016 reset=1 at any edge, including mid-transaction, SHALL force IDLE and counter=0.
REQ-017 During reset, every output SHALL be 0: in_ready, out_valid, all enables and modes, both addresses, dut_run, busy, done, timeout_err.

Configuration
REQ-018 With DUT_IO_SEQ_TIMEOUT_EN defined, a run counter SHALL count RUN cycles.
- Reaching TIMEOUT_CYCLES without dut_done SHALL go to CAPTURE and set timeout_err.
- timeout_err SHALL stay set until the next accepted start or reset.
REQ-019 Without DUT_IO_SEQ_TIMEOUT_EN, RUN SHALL wait for dut_done indefinitely, timeout_err SHALL be tied to 0, and no run counter SHALL exist.

Structure
REQ-020 State encoding and the clog2-based counter-width function SHALL reside in the shared package dut_io_pkg.
REQ-021 The word counter (clear, increment-on-enable, terminal-count flag) SHALL be one sub-module, dut_io_word_cnt, instantiated once and shared by LOAD and DRAIN.

Verification
REQ-022 Nominal: start; 8 words 0x11111111..0x88888888 with in_valid continuous; dut_done 5 cycles later -> 8 input writes at addresses 0..7, one CAPTURE pulse, 8 out words at addresses 0..7, done pulse, busy low.
REQ-023 Backpressure: out_ready toggled 1,0,0,1 during DRAIN -> address and out_word hold while stalled; no word is skipped or duplicated.
REQ-024 Input gaps: in_valid low for 3 cycles after word 2 -> no input_vec_en during the gap; word 3 is written to address 3.
REQ-025 Reset mid-RUN: reset for 1 cycle while dut_run=1 -> all outputs 0 next cycle; a new start completes normally.
REQ-026 Ignored start: start pulsed during LOAD -> counter and state unaffected.
REQ-027 Timeout (macro defined, TIMEOUT_CYCLES=16, dut_done held 0) -> CAPTURE after 16 RUN cycles, timeout_err=1 until the next start.
